// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and branch handling,
// multi-cycle mul/div and memory-wait freezes, plus a saturating stall counter.
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1_D,
    input  logic [4:0]  rs2_D,
    input  logic [4:0]  rs1_E,
    input  logic [4:0]  rs2_E,
    input  logic [4:0]  rd_E,
    input  logic [4:0]  rd_M,
    input  logic [4:0]  rd_W,
    input  logic        regWrite_M,
    input  logic        regWrite_W,
    input  logic        load_E,
    input  logic        pcSrc_E,
    input  logic        md_E,
    input  logic        mdDone,
    input  logic        memReq_M,
    input  logic        memReady,
    output logic        stall_F,
    output logic        stall_D,
    output logic        stall_E,
    output logic        stall_M,
    output logic        flush_D,
    output logic        flush_E,
    output logic        flush_M,
    output logic        flush_W,
    output logic [1:0]  forwardA_E,
    output logic [1:0]  forwardB_E,
    output logic        mdGo,
    output logic [15:0] stallCycles
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MD_WAIT  = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        lw_stall_s;
    logic        mem_freeze_s;

    // M result beats W result; x0 is never forwarded
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rdm, input logic wem,
                                           input logic [4:0] rdw, input logic wew);
        logic [1:0] sel;
        if (wem && (rdm != 5'd0) && (rdm == rs)) begin
            sel = 2'b10;
        end else if (wew && (rdw != 5'd0) && (rdw == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign lw_stall_s   = load_E && (rd_E != 5'd0) && ((rd_E == rs1_D) || (rd_E == rs2_D));
    assign mem_freeze_s = memReq_M && !memReady;

    // Next state and all control outputs; reset forces everything quiet
    always_comb begin
        state_d    = state_q;
        stall_F    = 1'b0;
        stall_D    = 1'b0;
        stall_E    = 1'b0;
        stall_M    = 1'b0;
        flush_D    = 1'b0;
        flush_E    = 1'b0;
        flush_M    = 1'b0;
        flush_W    = 1'b0;
        mdGo       = 1'b0;
        forwardA_E = 2'b00;
        forwardB_E = 2'b00;
        if (reset) begin
            state_d = IDLE;
        end else begin
            forwardA_E = fwd_sel(rs1_E, rd_M, regWrite_M, rd_W, regWrite_W);
            forwardB_E = fwd_sel(rs2_E, rd_M, regWrite_M, rd_W, regWrite_W);
            case (state_q)
                IDLE: begin
                    if (mem_freeze_s) begin
                        {stall_F, stall_D, stall_E, stall_M} = 4'b1111;
                        flush_W = 1'b1;
                        state_d = MEM_WAIT;
                    end else if (md_E) begin
                        {stall_F, stall_D, stall_E} = 3'b111;
                        flush_M = 1'b1;
                        mdGo    = 1'b1;
                        state_d = MD_WAIT;
                    end else if (pcSrc_E) begin
                        flush_D = 1'b1;
                        flush_E = 1'b1;
                    end else if (lw_stall_s) begin
                        stall_F = 1'b1;
                        stall_D = 1'b1;
                        flush_E = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                MD_WAIT: begin
                    // M holds a bubble here, so memory requests cannot occur
                    if (mdDone) begin
                        state_d = IDLE;
                    end else begin
                        {stall_F, stall_D, stall_E} = 3'b111;
                        flush_M = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_freeze_s) begin
                        {stall_F, stall_D, stall_E, stall_M} = 4'b1111;
                        flush_W = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Stall cycle counter, saturating at all-ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (reset) begin
            stall_cnt_d = 16'd0;
        end else if (stall_F && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        state_q     <= state_d;
        stall_cnt_q <= stall_cnt_d;
    end

    assign stallCycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl: vector table for the
// single-cycle decisions, hand-written sequences for the multi-cycle cases.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic        regWrite_M, regWrite_W, load_E, pcSrc_E, md_E, mdDone, memReq_M, memReady;
    logic        stall_F, stall_D, stall_E, stall_M;
    logic        flush_D, flush_E, flush_M, flush_W;
    logic [1:0]  forwardA_E, forwardB_E;
    logic        mdGo;
    logic [15:0] stallCycles;
    logic [12:0] out_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
        .rd_M(rd_M), .rd_W(rd_W), .regWrite_M(regWrite_M), .regWrite_W(regWrite_W),
        .load_E(load_E), .pcSrc_E(pcSrc_E), .md_E(md_E), .mdDone(mdDone),
        .memReq_M(memReq_M), .memReady(memReady),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M), .flush_W(flush_W),
        .forwardA_E(forwardA_E), .forwardB_E(forwardB_E), .mdGo(mdGo),
        .stallCycles(stallCycles)
    );

    // {sF,sD,sE,sM, fD,fE,fM,fW, fwdA, fwdB, mdGo}
    assign out_s = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_M, flush_W,
                    forwardA_E, forwardB_E, mdGo};

    localparam logic [12:0] O_NONE   = 13'b0000_0000_00_00_0;
    localparam logic [12:0] O_LW     = 13'b1100_0100_00_00_0;
    localparam logic [12:0] O_BR     = 13'b0000_1100_00_00_0;
    localparam logic [12:0] O_MEM    = 13'b1111_0001_00_00_0;
    localparam logic [12:0] O_MDGO   = 13'b1110_0010_00_00_1;
    localparam logic [12:0] O_MDWAIT = 13'b1110_0010_00_00_0;

    typedef struct {
        logic [4:0]  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
        logic        rwm, rww, ld, pc;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W} = 35'd0;
        {regWrite_M, regWrite_W, load_E, pcSrc_E, md_E, mdDone, memReq_M, memReady} = 8'd0;
    endtask

    task automatic cyc(input string name, input logic [12:0] exp);
        @(negedge clk);
        check(name, {3'b000, out_s}, {3'b000, exp});
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
        vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 13'b0000_0000_10_00_0};
        vecs[2]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 13'b0000_0000_01_00_0};
        vecs[3]  = '{5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 13'b0000_0000_00_01_0};
        vecs[4]  = '{5'd0, 5'd0, 5'd9, 5'd9, 5'd0, 5'd9, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 13'b0000_0000_01_01_0};
        vecs[5]  = '{5'd0, 5'd0, 5'd3, 5'd3, 5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 13'b0000_0000_10_10_0};
        vecs[6]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_LW};
        vecs[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, O_NONE};
        vecs[8]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE};
        vecs[9]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_BR};
        vecs[10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_BR};
        vecs[11] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, O_NONE};

        // Reset state, with forwarding and hazard inputs active
        reset = 1'b1;
        clear_inputs();
        rs1_E = 5'd5; rd_M = 5'd5; regWrite_M = 1'b1; load_E = 1'b1; rd_E = 5'd7; rs1_D = 5'd7;
        tick();
        @(negedge clk);
        check("reset_outputs", {3'b000, out_s}, {3'b000, O_NONE});
        check("reset_count", stallCycles, 16'd0);
        tick();
        reset = 1'b0;
        clear_inputs();

        for (int i = 0; i < 12; i++) begin
            rs1_D = vecs[i].rs1_D; rs2_D = vecs[i].rs2_D;
            rs1_E = vecs[i].rs1_E; rs2_E = vecs[i].rs2_E;
            rd_E = vecs[i].rd_E; rd_M = vecs[i].rd_M; rd_W = vecs[i].rd_W;
            regWrite_M = vecs[i].rwm; regWrite_W = vecs[i].rww;
            load_E = vecs[i].ld; pcSrc_E = vecs[i].pc;
            cyc($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Load-use lasts one cycle once the bubble reaches EX
        do_reset();
        load_E = 1'b1; rd_E = 5'd7; rs2_D = 5'd7;
        cyc("lw_cycle0", O_LW);
        load_E = 1'b0; rd_E = 5'd0;
        cyc("lw_cycle1", O_NONE);
        check("lw_count", stallCycles, 16'd1);

        // Mul/div: done four cycles after start; branch, load-use, memory ignored meanwhile
        do_reset();
        md_E = 1'b1;
        cyc("md_c0", O_MDGO);
        cyc("md_c1", O_MDWAIT);
        pcSrc_E = 1'b1; load_E = 1'b1; rd_E = 5'd7; rs1_D = 5'd7;
        cyc("md_c2_ignore_br", O_MDWAIT);
        pcSrc_E = 1'b0; load_E = 1'b0; rd_E = 5'd0; rs1_D = 5'd0;
        memReq_M = 1'b1; memReady = 1'b0;
        cyc("md_c3_ignore_mem", O_MDWAIT);
        memReq_M = 1'b0; mdDone = 1'b1;
        cyc("md_c4_done", O_NONE);
        md_E = 1'b0; mdDone = 1'b0;
        @(negedge clk);
        check("md_count", stallCycles, 16'd4);
        mdDone = 1'b1; load_E = 1'b1; rd_E = 5'd7; rs2_D = 5'd7;
        cyc("idle_mddone_ignored", O_LW);

        // Memory wait with mul/div pending: freeze first, then mul/div starts
        do_reset();
        md_E = 1'b1; memReq_M = 1'b1; memReady = 1'b0;
        for (int c = 0; c < 3; c++) cyc($sformatf("mem_freeze%0d", c), O_MEM);
        memReady = 1'b1;
        cyc("mem_release", O_NONE);
        memReq_M = 1'b0;
        cyc("mem_then_mdgo", O_MDGO);
        mdDone = 1'b1;
        cyc("mem_md_done", O_NONE);
        md_E = 1'b0; mdDone = 1'b0;
        @(negedge clk);
        check("mem_md_count", stallCycles, 16'd4);

        // Reset during MD_WAIT abandons it
        do_reset();
        md_E = 1'b1;
        cyc("rst_md_go", O_MDGO);
        cyc("rst_md_wait", O_MDWAIT);
        reset = 1'b1; rs1_E = 5'd5; rd_M = 5'd5; regWrite_M = 1'b1;
        cyc("rst_in_md_outputs", O_NONE);
        check("rst_in_md_count", stallCycles, 16'd0);
        reset = 1'b0; clear_inputs();
        cyc("rst_exit_no_mdgo", O_NONE);
        load_E = 1'b1; rd_E = 5'd7; rs1_D = 5'd7;
        cyc("rst_md_back_idle", O_LW);

        // Reset during MEM_WAIT abandons it
        do_reset();
        memReq_M = 1'b1; memReady = 1'b0;
        cyc("rst_mem_freeze", O_MEM);
        reset = 1'b1;
        cyc("rst_in_mem_outputs", O_NONE);
        reset = 1'b0; clear_inputs();
        load_E = 1'b1; rd_E = 5'd7; rs1_D = 5'd7;
        cyc("rst_mem_back_idle", O_LW);

        // Long freeze saturates the stall counter
        do_reset();
        memReq_M = 1'b1; memReady = 1'b0;
        repeat (65534) tick();
        check("sat_fffe", stallCycles, 16'hFFFE);
        tick();
        check("sat_ffff", stallCycles, 16'hFFFF);
        repeat (5) tick();
        check("sat_hold", stallCycles, 16'hFFFF);
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have clk  input  1  rising-edge clock.
REQ-002 SHALL have reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have rs1_D, rs2_D  input  5 each  source registers of the instruction in Decode.
REQ-004 SHALL have rs1_E, rs2_E, rd_E  input  5 each  source and destination registers in Execute.
REQ-005 SHALL have rd_M, rd_W  input  5 each  destination registers in Memory and Writeback.
REQ-006 SHALL have regWrite_M, regWrite_W  input  1 each  register-write enables of the M and W stages.
REQ-007 SHALL have load_E  input  1  EX instruction is a load.
REQ-008 SHALL have pcSrc_E  input  1  taken branch, jal or jalr resolved in EX.
REQ-009 SHALL have md_E  input  1  EX holds a multi-cycle mul/div operation.
REQ-010 SHALL have mdDone  input  1  one-cycle result-valid pulse from the mul/div unit.
REQ-011 SHALL have memReq_M, memReady  input  1 each  M-stage memory access and its ready flag.
REQ-012 SHALL have stall_F, stall_D, stall_E, stall_M  output  1 each  hold enables for the PC, IF_ID, ID_EX and EX_MEM registers.
REQ-013 SHALL have flush_D, flush_E, flush_M, flush_W  output  1 each  bubble insert into IF_ID, ID_EX, EX_MEM and MEM_WB.
REQ-014 SHALL have forwardA_E, forwardB_E  output  2 each  ALU operand select: 00 = register file, 01 = W result, 10 = M result.
REQ-015 SHALL have mdGo  output  1  start pulse to the mul/div unit.
REQ-016 SHALL have stallCycles  output  16  saturating count of stalled cycles.

Function
REQ-017 SHALL use three states: IDLE, MD_WAIT and MEM_WAIT.
REQ-018 SHALL derive the stall, flush, forward and mdGo outputs combinationally from the inputs and the registered state.
REQ-019 SHALL set forwardA_E to 10 when regWrite_M=1, rd_M!=0 and rd_M==rs1_E; otherwise to 01 when regWrite_W=1, rd_W!=0 and rd_W==rs1_E; otherwise to 00; M takes priority over W.
REQ-020 SHALL derive forwardB_E from rs2_E using the same rules as REQ-019.
REQ-021 SHALL define lwStall = load_E & (rd_E!=0) & ((rd_E==rs1_D) | (rd_E==rs2_D)).
REQ-022 SHALL, in IDLE with no freeze, drive on lwStall: stall_F=1, stall_D=1, flush_E=1.
REQ-023 SHALL, in IDLE with no freeze, drive on pcSrc_E: flush_D=1, flush_E=1.
REQ-024 SHALL let pcSrc_E win over lwStall when both are asserted in the same cycle: flush_D=1, flush_E=1, and stall_F and stall_D not asserted.
REQ-025 SHALL, when memReq_M=1 and memReady=0 (in IDLE or MEM_WAIT), assert the memory freeze in the same cycle: stall_F, stall_D, stall_E and stall_M=1, flush_W=1, all other flushes 0.
REQ-026 SHALL move IDLE to MEM_WAIT on the memory freeze condition.
REQ-027 SHALL move MEM_WAIT to IDLE in the cycle memReady=1; stalls drop that cycle.
REQ-028 SHALL, in IDLE with md_E=1 and no memory freeze, pulse mdGo=1 for one cycle, assert stall_F, stall_D and stall_E=1 plus flush_M=1, and enter MD_WAIT.
REQ-029 SHALL, in MD_WAIT, hold stall_F, stall_D and stall_E=1 and flush_M=1, and keep mdGo=0.
REQ-030 SHALL, in MD_WAIT when mdDone=1, release all stalls in that cycle and return to IDLE.
REQ-031 SHALL give the memory freeze priority over md_E: in IDLE with both asserted, enter MEM_WAIT with mdGo=0; md_E is re-evaluated on return to IDLE.
REQ-032 SHALL, in MD_WAIT, ignore pcSrc_E and lwStall.
REQ-033 SHALL give MD_WAIT precedence over memReq_M: the M stage holds a bubble, so memReq_M is ignored there.
REQ-034 SHALL ignore mdDone outside MD_WAIT.
REQ-035 SHALL increment stallCycles on every cycle with stall_F=1 and saturate it at 16'hFFFF.

Reset
REQ-036 SHALL, while reset=1, force state to IDLE, stallCycles to 0, and all stall, flush, mdGo and forward outputs to 0.
REQ-037 SHALL, on reset asserted mid MD_WAIT or MEM_WAIT, abandon the operation and return to IDLE on the next edge.
REQ-038 SHALL issue no mdGo pulse on reset exit.

Verification
REQ-039 SHALL be verified for forwarding: rd_M=5, regWrite_M=1, rd_W=5, regWrite_W=1, rs1_E=5 -> forwardA_E=10; with rd_M=0 -> forwardA_E=01.
REQ-040 SHALL be verified for load-use: load_E=1, rd_E=7, rs2_D=7 -> stall_F=1, stall_D=1, flush_E=1 for exactly one cycle; rd_E=0 -> no stall.
REQ-041 SHALL be verified for branch: pcSrc_E=1 together with lwStall -> flush_D=1, flush_E=1, stall_F=0.
REQ-042 SHALL be verified for mul/div: md_E=1 and mdDone arriving 4 cycles later -> mdGo high in cycle 0 only, stalls high for cycles 0-3, released in cycle 4, stallCycles=4.
REQ-043 SHALL be verified for memory wait: memReq_M=1 with memReady low for 3 cycles while md_E=1 -> full freeze for 3 cycles with mdGo=0, then MD_WAIT entry with mdGo=1.
REQ-044 SHALL be verified for saturation and reset: a freeze longer than 65535 cycles -> stallCycles=FFFF; reset asserted in MD_WAIT -> IDLE, all outputs 0.
